fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ requesters.
//  Sits in the wclk domain, in front of the FIFO write side.
//  Drives wdata/write_enable from granted requester's valid/ready stream.
//  Throttles on wfull, wr_almost_ful and wr_level so the FIFO never overflows.
// PARAMETERS
//  DATA_WIDTH     8   width of wdata and of each requester data lane
//  ADDRESS_WIDTH  4   FIFO address width; DEPTH = 2**ADDRESS_WIDTH
//  NUM_REQ        4   number of requesters (2..8)
//  MAX_BURST      4   max beats per grant before forced rotation (1..15)
// PORTS
//  wclk          in   1                     write-domain clock
//  sw_rst        in   1                     synchronous, active-high reset
//  req_valid     in   NUM_REQ               per-requester beat valid
//  req_data      in   NUM_REQ*DATA_WIDTH    requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last      in   NUM_REQ               beat is last of requester's burst
//  req_ready     out  NUM_REQ               beat accepted when req_valid[i]&req_ready[i]
//  wfull         in   1                     FIFO full
//  wr_almost_ful in   1                     FIFO almost full
//  wr_level      in   ADDRESS_WIDTH+1       FIFO occupancy, includes writes up to previous cycle
//  wdata         out  DATA_WIDTH            FIFO write data (registered)
//  write_enable  out  1                     FIFO write strobe (registered)
//  grant_id      out  $clog2(NUM_REQ)       current/last granted requester
//  busy          out  1                     1 while in BURST
//  overflow_err  out  1                     sticky: write_enable asserted while wfull
// BEHAVIOUR
//  Reset and clocking:
//  - One clock, wclk. sw_rst is synchronous and active-high.
//  - During reset, all outputs are 0.
//  - Reset sets the RR pointer to NUM_REQ-1, so requester 0 has highest priority first.
//  - Reset mid-burst drops the burst, clears beat_cnt, and returns to IDLE; no write issues that cycle.
//  FSM states: IDLE, BURST.
//  - IDLE -> BURST when |req_valid & !wfull & !wr_almost_ful.
//  - Grant goes to the first valid requester searching ptr+1, ptr+2, ... (mod NUM_REQ).
//  - grant_id is registered on entry to BURST.
//  - IDLE never asserts req_ready; arbitration costs 1 cycle.
//  Space and handshake:
//  - space_ok = !wfull && (wr_level + write_enable) < DEPTH. write_enable counts the in-flight write.
//  - In BURST: req_ready[grant_id] = space_ok; every other req_ready bit = 0. Combinational.
//  - Accepted beat in cycle N gives write_enable=1 and wdata=req_data[grant_id] in N+1.
//  - Latency is 1 cycle. Otherwise write_enable=0 and wdata holds its value.
//  Burst termination:
//  - beat_cnt counts accepted beats in the burst.
//  - Burst ends on an accepted beat with req_last=1, or with beat_cnt==MAX_BURST-1.
//  - On burst end: ptr<=grant_id, beat_cnt<=0, -> IDLE.
//  - Forced rotation leaves the requester's remaining beats for a later grant.
//  Stalls and throttling:
//  - Grant is locked in BURST. If the granted requester drops req_valid or space_ok=0, stay in BURST and stall.
//  - wr_almost_ful blocks only new grants; an active burst continues while space_ok.
//  Other rules:
//  - busy = (state==BURST).
//  - overflow_err sets when write_enable&&wfull and clears only on sw_rst.
//  - Widths: wr_level+write_enable is computed at ADDRESS_WIDTH+2 bits (no wrap).
//  - beat_cnt is $clog2(MAX_BURST+1) bits.
// TESTING
//  T1 single: req0 sends 3 beats 0x11,0x22,0x33 (last on 3rd), FIFO empty
//     -> write_enable high 3 cycles, wdata 11/22/33, first write 2 cycles after valid, then IDLE.
//  T2 fairness: all 4 requesters continuously valid, bursts of 2
//     -> grant_id sequence 0,1,2,3,0...; no requester gets >2 consecutive writes.
//  T3 forced rotation: req1 sends 10 beats with no last, MAX_BURST=4, req2 valid
//     -> req1 writes 4, req2 burst, then req1 resumes with its 5th beat.
//  T4 full: wr_level=DEPTH-1 mid-burst -> exactly 1 more write, req_ready=0 after it;
//     overflow_err stays 0; resumes on wr_level drop.
//  T5 almost full: wr_almost_ful=1 in IDLE with req valid -> stays IDLE, no grant;
//     asserted mid-burst -> burst completes.
//  T6 reset: sw_rst for 1 cycle during beat 2 of a burst
//     -> next cycle write_enable=0, busy=0, req_ready=0; next grant goes to req0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among NUM_REQ valid/ready requesters.
// The write path is registered; space accounting includes the write that is still in flight.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 4
) (
    input  logic                            wclk,
    input  logic                            sw_rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            wfull,
    input  logic                            wr_almost_ful,
    input  logic [ADDRESS_WIDTH:0]          wr_level,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic                            write_enable,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            overflow_err
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CW    = $clog2(MAX_BURST + 1);
    localparam int LW    = ADDRESS_WIDTH + 2;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        gnt_q, gnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] lane [NUM_REQ];
    logic [LW-1:0]         level_sum;
    logic                  space_ok;
    logic                  accept;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester after p, wrapping; scanning backwards lets the nearest one win.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDW-1:0] p);
        logic [IDW-1:0] r;
        int idx;
        r = p;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (v[idx]) r = IDW'(idx);
        end
        return r;
    endfunction

    assign level_sum = LW'(wr_level) + LW'(we_q);
    assign space_ok  = !wfull && (level_sum < LW'(DEPTH));
    assign accept    = (state_q == BURST) && req_valid[gnt_q] && space_ok;
    assign req_ready = (state_q == BURST && space_ok && !sw_rst) ?
                       (NUM_REQ'(1) << gnt_q) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        ovf_d   = ovf_q | (we_q & wfull);
        case (state_q)
            IDLE: begin
                if (|req_valid && !wfull && !wr_almost_ful) begin
                    gnt_d   = rr_pick(req_valid, ptr_q);
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    we_d    = 1'b1;
                    wdata_d = lane[gnt_q];
                    // Forced rotation leaves the rest of the burst for a later grant.
                    if (req_last[gnt_q] || cnt_q == CW'(MAX_BURST - 1)) begin
                        ptr_d   = gnt_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (sw_rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NUM_REQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wdata        = wdata_q;
    assign write_enable = we_q;
    assign grant_id     = gnt_q;
    assign busy         = (state_q == BURST);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat queues, a FIFO occupancy stand-in,
// and a transaction-level reference checked against the DUT every cycle.
module tb_fifo_wr_arbiter;
    localparam int NR = 4, DW = 8, AW = 4, MB = 4, DEPTH = 16, SZ = 256;

    logic              wclk = 1'b0;
    logic              sw_rst;
    logic [NR-1:0]     req_valid, req_last, req_ready;
    logic [NR*DW-1:0]  req_data;
    logic              wfull, wr_almost_ful;
    logic [AW:0]       wr_level;
    logic [DW-1:0]     wdata;
    logic              write_enable;
    logic [1:0]        grant_id;
    logic              busy, overflow_err;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wclk(wclk), .sw_rst(sw_rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wfull(wfull),
        .wr_almost_ful(wr_almost_ful), .wr_level(wr_level), .wdata(wdata),
        .write_enable(write_enable), .grant_id(grant_id), .busy(busy),
        .overflow_err(overflow_err)
    );

    always #5 wclk = ~wclk;

    // requester beat queues and environment knobs
    logic [DW-1:0] sd [NR][SZ];
    bit            sl [NR][SZ];
    int            hd [NR];
    int            tl [NR];
    bit            rnd_mode = 0, almost_force = 0, drain_en = 0, chk_en = 0;
    int            occ = 0, cyc = 0;

    // reference model state
    bit            m_busy = 0, m_we = 0, m_ovf = 0;
    int            m_gnt = 0, m_ptr = NR - 1, m_beats = 0;
    logic [DW-1:0] m_wdata = '0;

    // log of writes the model expects, with the cycle in which write_enable is high
    int            log_n = 0;
    int            log_id  [64];
    logic [DW-1:0] log_data[64];
    int            log_cyc [64];

    int tests = 0, fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_space();
        return !wfull && (int'(wr_level) + int'(m_we)) < DEPTH;
    endfunction

    // Reference: one burst owner at a time, chosen round-robin after the last owner,
    // beats move one cycle after being accepted, at most MB beats per grant.
    always @(posedge wclk) begin
        bit sp;
        cyc++;
        if (!rnd_mode) begin
            occ = occ + int'(m_we);
            if (drain_en && occ > 0) occ--;
        end
        if (sw_rst) begin
            m_busy = 0; m_we = 0; m_ovf = 0; m_gnt = 0; m_ptr = NR - 1;
            m_beats = 0; m_wdata = '0;
        end else begin
            sp = m_space();
            m_ovf = m_ovf | (m_we && wfull);
            m_we = 0;
            if (!m_busy) begin
                if (req_valid != '0 && !wfull && !wr_almost_ful) begin
                    for (int k = 1; k <= NR; k++) begin
                        if (req_valid[(m_ptr + k) % NR]) begin
                            m_gnt = (m_ptr + k) % NR;
                            break;
                        end
                    end
                    m_busy = 1;
                    m_beats = 0;
                end
            end else if (req_valid[m_gnt] && sp) begin
                m_we = 1;
                m_wdata = req_data[m_gnt*DW +: DW];
                hd[m_gnt]++;
                if (log_n < 64) begin
                    log_id[log_n] = m_gnt; log_data[log_n] = m_wdata; log_cyc[log_n] = cyc;
                end
                log_n++;
                m_beats++;
                if (req_last[m_gnt] || m_beats == MB) begin
                    m_ptr = m_gnt;
                    m_busy = 0;
                end
            end
        end
    end

    // drive requesters and FIFO status just after each edge
    always @(posedge wclk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            bit g;
            g = rnd_mode ? ($urandom % 4 != 0) : 1'b1;
            req_valid[i] = (hd[i] < tl[i]) && g;
            req_data[i*DW +: DW] = sd[i][hd[i] % SZ];
            req_last[i] = sl[i][hd[i] % SZ];
        end
        if (rnd_mode) begin
            wfull = ($urandom % 8 == 0);
            wr_almost_ful = ($urandom % 6 == 0);
            wr_level = 5'($urandom_range(0, DEPTH));
        end else begin
            wr_level = 5'((occ > DEPTH) ? DEPTH : occ);
            wfull = (occ >= DEPTH);
            wr_almost_ful = almost_force;
        end
    end

    always @(negedge wclk) begin
        if (chk_en) begin
            logic [NR-1:0] er;
            er = '0;
            if (!sw_rst && m_busy && m_space()) er[m_gnt] = 1'b1;
            check("write_enable", write_enable, m_we);
            check("wdata", wdata, m_wdata);
            check("grant_id", grant_id, m_gnt);
            check("busy", busy, m_busy);
            check("overflow_err", overflow_err, m_ovf);
            check("req_ready", req_ready, er);
        end
    end

    task automatic push(input int i, input logic [DW-1:0] d, input bit l);
        sd[i][tl[i] % SZ] = d;
        sl[i][tl[i] % SZ] = l;
        tl[i]++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge wclk); #2; end
    endtask

    task automatic do_reset();
        tick(1);
        sw_rst = 1;
        for (int i = 0; i < NR; i++) hd[i] = tl[i];
        tick(1);
        sw_rst = 0;
        log_n = 0; occ = 0; almost_force = 0; drain_en = 0;
    endtask

    task automatic wait_log(input int n, input string nm);
        int k;
        k = 0;
        while (log_n < n && k < 200) begin tick(1); k++; end
        check(nm, 32'(log_n >= n), 1);
    endtask

    int            t0;
    int            e3id [12] = '{1, 1, 1, 1, 2, 2, 1, 1, 1, 1, 1, 1};
    logic [DW-1:0] e3d  [12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21,
                                 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};

    initial begin
        sw_rst = 1; req_valid = '0; req_data = '0; req_last = '0;
        wfull = 0; wr_almost_ful = 0; wr_level = '0;
        for (int i = 0; i < NR; i++) begin hd[i] = 0; tl[i] = 0; end
        tick(3);
        chk_en = 1;
        check("rst_we", write_enable, 0);
        check("rst_wdata", wdata, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_ready", req_ready, 0);
        sw_rst = 0;

        // single requester, three beats
        do_reset();
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
        t0 = cyc + 1;
        wait_log(3, "t1_wait");
        check("t1_d0", log_data[0], 8'h11);
        check("t1_d1", log_data[1], 8'h22);
        check("t1_d2", log_data[2], 8'h33);
        check("t1_id", log_id[2], 0);
        check("t1_latency", log_cyc[0] - t0, 2);
        check("t1_b2b", log_cyc[2] - log_cyc[0], 2);
        check("t1_idle", busy, 0);

        // fairness with bursts of two
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 8; k++) push(i, 8'(i * 16 + k), (k % 2) == 1);
        wait_log(16, "t2_wait");
        for (int k = 0; k < 16; k++) begin
            check("t2_id", log_id[k], (k / 2) % 4);
            check("t2_data", log_data[k], ((k / 2) % 4) * 16 + 2 * (k / 8) + k % 2);
        end

        // forced rotation after MB beats
        do_reset();
        for (int k = 0; k < 10; k++) push(1, 8'(8'h10 + k), 0);
        push(2, 8'h20, 0); push(2, 8'h21, 1);
        wait_log(12, "t3_wait");
        for (int k = 0; k < 12; k++) begin
            check("t3_id", log_id[k], e3id[k]);
            check("t3_data", log_data[k], e3d[k]);
        end

        // FIFO filling mid-burst: from 13 entries exactly three more fit
        do_reset();
        occ = 13;
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 0); push(0, 8'h44, 1);
        wait_log(3, "t4_wait");
        tick(8);
        check("t4_count", log_n, 3);
        check("t4_ovf", overflow_err, 0);
        check("t4_ready", req_ready, 0);
        check("t4_busy", busy, 1);
        drain_en = 1;
        wait_log(4, "t4_resume");
        check("t4_last", log_data[3], 8'h44);
        drain_en = 0;

        // almost-full blocks grants but not an active burst
        do_reset();
        almost_force = 1;
        push(0, 8'h51, 0); push(0, 8'h52, 0); push(0, 8'h53, 1);
        tick(6);
        check("t5_nogrant", log_n, 0);
        check("t5_idle", busy, 0);
        almost_force = 0;
        wait_log(1, "t5_start");
        almost_force = 1;
        wait_log(3, "t5_finish");
        check("t5_data", log_data[2], 8'h53);
        check("t5_done", busy, 0);

        // reset during the second beat
        do_reset();
        push(0, 8'h61, 0); push(0, 8'h62, 0); push(0, 8'h63, 0); push(0, 8'h64, 1);
        wait_log(1, "t6_start");
        sw_rst = 1;
        tick(1);
        sw_rst = 0;
        check("t6_we", write_enable, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", req_ready, 0);
        log_n = 0;
        push(3, 8'h71, 1);
        wait_log(4, "t6_wait");
        check("t6_id0", log_id[0], 0);
        check("t6_d0", log_data[0], 8'h62);
        check("t6_id3", log_id[3], 3);

        // randomized traffic, FIFO status and occasional resets
        do_reset();
        rnd_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            sw_rst = ($urandom % 300 == 0);
            for (int i = 0; i < NR; i++)
                if (tl[i] - hd[i] < 6 && $urandom % 3 == 0)
                    push(i, 8'($urandom), $urandom % 3 == 0);
        end
        sw_rst = 0;
        rnd_mode = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
